// File: rtl/coax_pkg.sv
// Shared definitions for the 3270 coax transmit path: word width and buffer FSM states.
package coax_pkg;

    localparam int unsigned COAX_WORD_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } coax_state_t;

endpackage

// File: rtl/coax_fifo.sv
// Generic synchronous show-ahead FIFO with registered count/full/empty.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module coax_fifo #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned WORD_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_ok;
    logic                  wr_ok;
    logic [ADDR_WIDTH:0]   count_next;

    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok) begin
            count_next = count + (ADDR_WIDTH+1)'(1);
        end else if (!wr_ok && rd_ok) begin
            count_next = count - (ADDR_WIDTH+1)'(1);
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count <= count_next;
            full  <= (count_next == (ADDR_WIDTH+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/coax_tx_buffer.sv
// Frame buffer feeding coax_tx: queues host words, sends them back-to-back on start, pulses done.
// Optional COAX_TX_BUFFER_LEVEL_EN exposes the current FIFO fill level on port level.
module coax_tx_buffer
    import coax_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned WORD_WIDTH = COAX_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  wr_strobe,
    output logic                  full,
    output logic                  empty,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic                  tx_active,
    input  logic                  clear_status
`ifdef COAX_TX_BUFFER_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    coax_state_t           state;
    logic                  pop;
    logic                  overflow_set;
    logic [WORD_WIDTH-1:0] head_data;
    logic [ADDR_WIDTH:0]   fifo_count;

    assign pop          = tx_valid && tx_ready;
    assign overflow_set = wr_strobe && full && !pop;
    // Show-ahead head word is only presented while a word is being offered.
    assign tx_data      = tx_valid ? head_data : '0;

    coax_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_strobe),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head_data),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

`ifdef COAX_TX_BUFFER_LEVEL_EN
    assign level = fifo_count;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow_set || (overflow && !clear_status);
        end
    end

    // Frame FSM; tx_valid stays high for all of SEND since SEND is never entered or held while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !empty) begin
                        state    <= SEND;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (pop && (fifo_count == (ADDR_WIDTH+1)'(1)) && !wr_strobe) begin
                        state    <= DRAIN;
                        tx_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!tx_active) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coax_tx_buffer.sv
// Directed bench for coax_tx_buffer with hand-computed expected words and timing.
module tb_coax_tx_buffer;

    logic       clk;
    logic       reset_n;
    logic [9:0] wr_data;
    logic       wr_strobe;
    logic       full;
    logic       empty;
    logic       start;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [9:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_active;
    logic       clear_status;
`ifdef COAX_TX_BUFFER_LEVEL_EN
    logic [5:0] level;
`endif

    int vectors;
    int miscompares;

    logic [9:0] got[$];
    int done_cnt;
    int stable_bad;
    int gaps;
    int timed_out;
    int first_pop;
    int last_pop;

    coax_tx_buffer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_data      (wr_data),
        .wr_strobe    (wr_strobe),
        .full         (full),
        .empty        (empty),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_active    (tx_active),
        .clear_status (clear_status)
`ifdef COAX_TX_BUFFER_LEVEL_EN
        ,
        .level        (level)
`endif
    );

    initial clk = 1'b0;
    always #26 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [9:0] w);
        wr_data   = w;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Plays coax_tx: drives tx_ready (mode 0 always, mode 1 pattern 1,0,0), records pops,
    // drops tx_active two cycles after the n-th pop, stops a few cycles after done.
    task automatic collect(input int n, input int mode, input int budget,
                           input int start_c, input int wr_c, input logic [9:0] wr_w);
        int since;
        int after_done;
        logic stall;
        logic [9:0] held;
        since = 0; after_done = 0;
        done_cnt = 0; stable_bad = 0; gaps = 0; timed_out = 1;
        first_pop = -1; last_pop = -1;
        tx_active = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tx_ready  = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            start     = (c == start_c);
            wr_strobe = (c == wr_c);
            wr_data   = wr_w;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            if (!tx_valid && got.size() > 0 && got.size() < n) gaps++;
            stall = tx_valid && !tx_ready;
            held  = tx_data;
            tick();
            start = 1'b0;
            wr_strobe = 1'b0;
            if (stall && tx_data !== held) stable_bad++;
            if (done) done_cnt++;
            if (got.size() >= n) since++;
            if (since >= 2) tx_active = 1'b0;
            if (done_cnt > 0) after_done++;
            if (after_done >= 3) begin
                timed_out = 0;
                break;
            end
        end
        tx_ready = 1'b0;
        tx_active = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0b want 0", full); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %0b want 1", empty); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b want 0", done); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %0b want 0", tx_valid); end
        vectors++; if (tx_data !== 10'h000) begin miscompares++; $display("FAIL reset_tx_data: got %0h want 0", tx_data); end
    endtask

    task automatic test_basic_frame();
        logic [9:0] exp_w[$];
        exp_w = '{10'h001, 10'h2AA, 10'h3FF};
        foreach (exp_w[i]) write_word(exp_w[i]);
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL basic_not_empty: got %0b want 0", empty); end
        pulse_start();
        vectors++; if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL basic_start_latency: got %0b want 1", tx_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %0b want 1", busy); end
        got.delete();
        collect(3, 0, 40, -1, -1, 10'h000);
        vectors++; if (timed_out !== 0) begin miscompares++; $display("FAIL basic_timeout: got %0d want 0", timed_out); end
        vectors++; if (got.size() !== 3) begin miscompares++; $display("FAIL basic_pop_count: got %0d want 3", got.size()); end
        for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
            vectors++; if (got[i] !== exp_w[i]) begin miscompares++; $display("FAIL basic_word%0d: got %0h want %0h", i, got[i], exp_w[i]); end
        end
        vectors++; if (last_pop - first_pop !== 2) begin miscompares++; $display("FAIL basic_back_to_back: got span %0d want 2", last_pop - first_pop); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL basic_empty_end: got %0b want 1", empty); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_end: got %0b want 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [9:0] exp_w[$];
        exp_w = '{10'h011, 10'h122, 10'h233, 10'h344};
        foreach (exp_w[i]) write_word(exp_w[i]);
        pulse_start();
        got.delete();
        collect(4, 1, 60, -1, -1, 10'h000);
        vectors++; if (timed_out !== 0) begin miscompares++; $display("FAIL bp_timeout: got %0d want 0", timed_out); end
        vectors++; if (got.size() !== 4) begin miscompares++; $display("FAIL bp_pop_count: got %0d want 4", got.size()); end
        for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
            vectors++; if (got[i] !== exp_w[i]) begin miscompares++; $display("FAIL bp_word%0d: got %0h want %0h", i, got[i], exp_w[i]); end
        end
        vectors++; if (stable_bad !== 0) begin miscompares++; $display("FAIL bp_data_stable: got %0d changes want 0", stable_bad); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 32; i++) begin
            write_word(10'(i * 37));
            if (i == 30) begin
                vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL full_at_31: got %0b want 0", full); end
            end
        end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_at_32: got %0b want 1", full); end
`ifdef COAX_TX_BUFFER_LEVEL_EN
        vectors++; if (level !== 6'd32) begin miscompares++; $display("FAIL level_at_32: got %0d want 32", level); end
`endif
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_before_33: got %0b want 0", overflow); end
        write_word(10'h155);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_after_33: got %0b want 1", overflow); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_after_33: got %0b want 1", full); end
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_cleared: got %0b want 0", overflow); end
    endtask

    task automatic test_full_write_pop();
        pulse_start();
        vectors++; if (tx_valid !== 1'b1) begin miscompares++; $display("FAIL fwp_valid: got %0b want 1", tx_valid); end
        got.delete();
        tx_ready  = 1'b1;
        tx_active = 1'b1;
        wr_data   = 10'h3C3;
        wr_strobe = 1'b1;
        got.push_back(tx_data);
        tick();
        wr_strobe = 1'b0;
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fwp_still_full: got %0b want 1", full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fwp_no_overflow: got %0b want 0", overflow); end
`ifdef COAX_TX_BUFFER_LEVEL_EN
        vectors++; if (level !== 6'd32) begin miscompares++; $display("FAIL fwp_level: got %0d want 32", level); end
`endif
        collect(33, 0, 120, -1, -1, 10'h000);
        vectors++; if (timed_out !== 0) begin miscompares++; $display("FAIL fwp_timeout: got %0d want 0", timed_out); end
        vectors++; if (got.size() !== 33) begin miscompares++; $display("FAIL fwp_pop_count: got %0d want 33", got.size()); end
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            vectors++; if (got[i] !== 10'(i * 37)) begin miscompares++; $display("FAIL fwp_word%0d: got %0h want %0h", i, got[i], 10'(i * 37)); end
        end
        if (got.size() > 32) begin
            vectors++; if (got[32] !== 10'h3C3) begin miscompares++; $display("FAIL fwp_last_word: got %0h want 3c3", got[32]); end
        end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL fwp_done_pulses: got %0d want 1", done_cnt); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fwp_empty_end: got %0b want 1", empty); end
    endtask

    task automatic test_start_empty();
        int dcount;
        dcount = 0;
        pulse_start();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL se_busy: got %0b want 0", busy); end
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL se_tx_valid: got %0b want 0", tx_valid); end
        for (int i = 0; i < 4; i++) begin
            if (done) dcount++;
            tick();
        end
        vectors++; if (dcount !== 0) begin miscompares++; $display("FAIL se_done: got %0d pulses want 0", dcount); end
    endtask

    task automatic test_start_during_send();
        logic [9:0] exp_w[$];
        exp_w = '{10'h005, 10'h006, 10'h007};
        foreach (exp_w[i]) write_word(exp_w[i]);
        pulse_start();
        got.delete();
        collect(3, 0, 40, 1, -1, 10'h000);
        vectors++; if (got.size() !== 3) begin miscompares++; $display("FAIL sds_pop_count: got %0d want 3", got.size()); end
        for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
            vectors++; if (got[i] !== exp_w[i]) begin miscompares++; $display("FAIL sds_word%0d: got %0h want %0h", i, got[i], exp_w[i]); end
        end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL sds_done_pulses: got %0d want 1", done_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sds_busy_end: got %0b want 0", busy); end
    endtask

    task automatic test_extend_frame();
        logic [9:0] exp_w[$];
        exp_w = '{10'h0F0, 10'h10F, 10'h2C2};
        write_word(exp_w[0]);
        write_word(exp_w[1]);
        pulse_start();
        got.delete();
        collect(3, 0, 40, -1, 1, exp_w[2]);
        vectors++; if (timed_out !== 0) begin miscompares++; $display("FAIL ext_timeout: got %0d want 0", timed_out); end
        vectors++; if (got.size() !== 3) begin miscompares++; $display("FAIL ext_pop_count: got %0d want 3", got.size()); end
        for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
            vectors++; if (got[i] !== exp_w[i]) begin miscompares++; $display("FAIL ext_word%0d: got %0h want %0h", i, got[i], exp_w[i]); end
        end
        vectors++; if (gaps !== 0) begin miscompares++; $display("FAIL ext_valid_gaps: got %0d want 0", gaps); end
        vectors++; if (last_pop - first_pop !== 2) begin miscompares++; $display("FAIL ext_back_to_back: got span %0d want 2", last_pop - first_pop); end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL ext_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 8; i++) write_word(10'(10'h040 + i));
        pulse_start();
        tx_ready  = 1'b1;
        tx_active = 1'b1;
        tick();
        tick();
        vectors++; if (tx_data !== 10'h042) begin miscompares++; $display("FAIL rst_head_after_2: got %0h want 42", tx_data); end
        #5 reset_n = 1'b0;
        #1;
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_tx_valid: got %0b want 0", tx_valid); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %0b want 1", empty); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b want 0", busy); end
        vectors++; if (tx_data !== 10'h000) begin miscompares++; $display("FAIL rst_tx_data: got %0h want 0", tx_data); end
        tx_ready  = 1'b0;
        tx_active = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        pulse_start();
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_post_busy: got %0b want 0", busy); end
        vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_post_tx_valid: got %0b want 0", tx_valid); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_post_empty: got %0b want 1", empty); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset_n = 1'b0;
        wr_data = '0;
        wr_strobe = 1'b0;
        start = 1'b0;
        tx_ready = 1'b0;
        tx_active = 1'b0;
        clear_status = 1'b0;
        #100;
        test_reset();
        reset_n = 1'b1;
        tick();
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_full_overflow();
        test_full_write_pop();
        test_start_empty();
        test_start_during_send();
        test_extend_frame();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
